// File: rtl/reset_sequencer_pkg.sv
// Shared types for the camera-pipeline reset sequencer.
// FSM encoding, stage indices and counter load helper.
package reset_sequencer_pkg;

    typedef enum logic [2:0] {
        HOLD,
        RELEASE,
        DELAY,
        WAIT_ACK,
        DONE,
        FAULT
    } state_e;

    typedef enum logic [2:0] {
        STG_SCCB = 3'd0,
        STG_CAP  = 3'd1,
        STG_FB   = 3'd2,
        STG_VGA  = 3'd3
    } stage_e;

    localparam int CNT_W = 32;

    // A programmed count of 0 behaves like 1: both load 0.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned v);
        return (v <= 1) ? '0 : CNT_W'(v - 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Bundle between the reset generator side and the reset sequencer.
// master drives the raw resets and acks, slave is the sequencer.
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    logic                  rstn;
    logic                  rst_done;
    logic                  soft_rst;
    logic [NUM_STAGES-1:0] stage_ack;
    logic [NUM_STAGES-1:0] stage_rstn;
    logic [2:0]            stage_idx;
    logic                  all_done;
    logic                  fault;

    modport master (
        output rstn, rst_done, soft_rst, stage_ack,
        input  stage_rstn, stage_idx, all_done, fault
    );

    modport slave (
        input  rstn, rst_done, soft_rst, stage_ack,
        output stage_rstn, stage_idx, all_done, fault
    );
endinterface

// File: rtl/reset_sequencer_reset_sync.sv
// Async-assert, sync-deassert reset synchroniser (active-low in/out).
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_arst_n,
    output logic o_rst_n
);
    localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [N-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[N-2:0], 1'b1};
        end
    end

    assign o_rst_n = r_sync[N-1];
endmodule

// File: rtl/reset_sequencer.sv
// Releases pipeline stage resets in order, each after a delay and an ack.
// Reports completion or an ack timeout fault.
module reset_sequencer #(
    parameter int          NUM_STAGES  = 4,
    parameter int unsigned STAGE_DELAY = 1000,
    parameter int unsigned ACK_TIMEOUT = 1000000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                  i_rst_clk,
    input  logic                  i_rstn,
    input  logic                  i_rst_done,
    input  logic                  i_soft_rst,
    input  logic [NUM_STAGES-1:0] i_stage_ack,
    output logic [NUM_STAGES-1:0] o_stage_rstn,
    output logic [2:0]            o_stage_idx,
    output logic                  o_all_done,
    output logic                  o_fault
);
    import reset_sequencer_pkg::*;

    localparam logic [CNT_W-1:0] DLY_LD = cnt_load(STAGE_DELAY);
    localparam logic [CNT_W-1:0] TO_LD  = cnt_load(ACK_TIMEOUT);
    localparam logic [2:0]       LAST   = 3'(NUM_STAGES - 1);

    logic w_rst_sync_n;
    logic w_soft_arst_n;
    logic w_soft_n;
    logic w_seq_rst_n;

    reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rstn_sync (
        .i_clk    (i_rst_clk),
        .i_arst_n (i_rstn),
        .o_rst_n  (w_rst_sync_n)
    );

    assign w_soft_arst_n = ~i_soft_rst;

    reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_soft_sync (
        .i_clk    (i_rst_clk),
        .i_arst_n (w_soft_arst_n),
        .o_rst_n  (w_soft_n)
    );

    // Either source restarts: clears at once, releases on a clock edge.
    assign w_seq_rst_n = w_rst_sync_n & w_soft_n;

    state_e                  r_state, w_state_nxt;
    logic [2:0]              r_idx, w_idx_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic [NUM_STAGES-1:0]   r_rel, w_rel_nxt;
    logic                    w_ack;

    always_ff @(posedge i_rst_clk or negedge w_seq_rst_n) begin
        if (!w_seq_rst_n) begin
            r_state <= HOLD;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_rel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rel   <= w_rel_nxt;
        end
    end

    always_comb begin
        w_ack       = 1'b0;
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_rel_nxt   = r_rel;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (r_idx == 3'(k)) w_ack = i_stage_ack[k];
        end
        unique case (r_state)
            HOLD: begin
                if (i_rst_done) begin
                    w_state_nxt = RELEASE;
                    w_idx_nxt   = STG_SCCB;
                end
            end
            RELEASE: begin
                w_state_nxt = DELAY;
                w_cnt_nxt   = DLY_LD;
            end
            DELAY: begin
                // Leave on the cycle whose decrement reaches zero.
                if (r_cnt <= 1) begin
                    w_state_nxt = WAIT_ACK;
                    w_cnt_nxt   = TO_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            WAIT_ACK: begin
                if (w_ack) begin
                    if (r_idx == LAST) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = RELEASE;
                        w_idx_nxt   = r_idx + 3'd1;
                    end
                end else if (r_cnt == '0) begin
                    w_state_nxt = FAULT;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            DONE, FAULT: begin
            end
            default: w_state_nxt = HOLD;
        endcase
        if (w_state_nxt == RELEASE) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (w_idx_nxt == 3'(k)) w_rel_nxt[k] = 1'b1;
            end
        end
    end

    always_comb begin
        o_stage_rstn = r_rel;
        o_stage_idx  = r_idx;
        o_all_done   = (r_state == DONE);
        o_fault      = (r_state == FAULT);
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: expected output changes queued by stimulus, checked by monitor.
module tb_reset_sequencer;
    import reset_sequencer_pkg::*;

    typedef logic [8:0] obs_t;
    typedef struct {
        int    cyc;
        obs_t  o;
        string nm;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_err = 0;
    int   n_chk = 0;
    exp_t exp0[$];
    exp_t exp1[$];
    obs_t prev0 = '1;
    obs_t prev1 = '1;

    reset_sequencer_if #(.NUM_STAGES(4)) bus0 ();
    reset_sequencer_if #(.NUM_STAGES(4)) bus1 ();

    reset_sequencer #(
        .NUM_STAGES(4), .STAGE_DELAY(10),
        .ACK_TIMEOUT(100), .SYNC_STAGES(2)
    ) u_dut0 (
        .i_rst_clk    (clk),
        .i_rstn       (bus0.rstn),
        .i_rst_done   (bus0.rst_done),
        .i_soft_rst   (bus0.soft_rst),
        .i_stage_ack  (bus0.stage_ack),
        .o_stage_rstn (bus0.stage_rstn),
        .o_stage_idx  (bus0.stage_idx),
        .o_all_done   (bus0.all_done),
        .o_fault      (bus0.fault)
    );

    reset_sequencer #(
        .NUM_STAGES(4), .STAGE_DELAY(10),
        .ACK_TIMEOUT(20), .SYNC_STAGES(2)
    ) u_dut1 (
        .i_rst_clk    (clk),
        .i_rstn       (bus1.rstn),
        .i_rst_done   (bus1.rst_done),
        .i_soft_rst   (bus1.soft_rst),
        .i_stage_ack  (bus1.stage_ack),
        .o_stage_rstn (bus1.stage_rstn),
        .o_stage_idx  (bus1.stage_idx),
        .o_all_done   (bus1.all_done),
        .o_fault      (bus1.fault)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input int w, input int c, input logic [3:0] r,
                        input logic [2:0] i, input logic d, input logic f,
                        input string nm);
        exp_t e;
        e.cyc = c;
        e.o   = {r, i, d, f};
        e.nm  = nm;
        if (w == 0) exp0.push_back(e);
        else        exp1.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic score(input int w, input obs_t a);
        exp_t e;
        bit   got;
        got = 1'b0;
        n_chk++;
        if (w == 0 && exp0.size() > 0) begin
            e = exp0.pop_front();
            got = 1'b1;
        end else if (w == 1 && exp1.size() > 0) begin
            e = exp1.pop_front();
            got = 1'b1;
        end
        if (!got) begin
            n_err++;
            $display("FAIL dut%0d unexpected change: rstn=%b idx=%0d done=%b fault=%b @cyc %0d",
                     w, a[8:5], a[4:2], a[1], a[0], cyc);
        end else if (a !== e.o || (e.cyc >= 0 && e.cyc != cyc)) begin
            n_err++;
            $display("FAIL dut%0d %s: got rstn=%b idx=%0d done=%b fault=%b @cyc %0d, expected rstn=%b idx=%0d done=%b fault=%b @cyc %0d",
                     w, e.nm, a[8:5], a[4:2], a[1], a[0], cyc,
                     e.o[8:5], e.o[4:2], e.o[1], e.o[0], e.cyc);
        end
    endtask

    initial forever begin
        obs_t a0;
        obs_t a1;
        @(negedge clk);
        a0 = {bus0.stage_rstn, bus0.stage_idx, bus0.all_done, bus0.fault};
        a1 = {bus1.stage_rstn, bus1.stage_idx, bus1.all_done, bus1.fault};
        if (a0 != prev0) begin
            prev0 = a0;
            score(0, a0);
        end
        if (a1 != prev1) begin
            prev1 = a1;
            score(1, a1);
        end
    end

    task automatic seq0();
        int c;
        int u;
        tick(3);
        c = cyc;
        push(0, c + 3,  4'b0001, 3'd0, 1'b0, 1'b0, "nom rel0");
        push(0, c + 14, 4'b0011, 3'd1, 1'b0, 1'b0, "nom rel1");
        push(0, c + 25, 4'b0111, 3'd2, 1'b0, 1'b0, "nom rel2");
        push(0, c + 36, 4'b1111, 3'd3, 1'b0, 1'b0, "nom rel3");
        push(0, c + 47, 4'b1111, 3'd3, 1'b1, 1'b0, "nom done");
        bus0.rstn = 1'b1;
        tick(55);
        push(0, cyc, 4'b0000, 3'd0, 1'b0, 1'b0, "async drop");
        bus0.rstn = 1'b0;
        #1;
        chk("async rstn before edge", int'(bus0.stage_rstn), 0);
        chk("async fsm hold", int'(u_dut0.r_state), int'(HOLD));
        tick(3);
        bus0.stage_ack = 4'b1011;
        c = cyc;
        push(0, c + 3,  4'b0001, 3'd0, 1'b0, 1'b0, "late rel0");
        push(0, c + 14, 4'b0011, 3'd1, 1'b0, 1'b0, "late rel1");
        push(0, c + 25, 4'b0111, 3'd2, 1'b0, 1'b0, "late rel2");
        push(0, c + 85, 4'b1111, 3'd3, 1'b0, 1'b0, "late rel3");
        push(0, c + 96, 4'b1111, 3'd3, 1'b1, 1'b0, "late done");
        bus0.rstn = 1'b1;
        tick(84);
        bus0.stage_ack = 4'b1111;
        tick(20);
        push(0, cyc, 4'b0000, 3'd0, 1'b0, 1'b0, "soft from done");
        bus0.soft_rst = 1'b1;
        tick(5);
        u = cyc;
        push(0, u + 3,  4'b0001, 3'd0, 1'b0, 1'b0, "soft1 rel0");
        push(0, u + 14, 4'b0011, 3'd1, 1'b0, 1'b0, "soft1 rel1");
        push(0, u + 25, 4'b0111, 3'd2, 1'b0, 1'b0, "soft1 rel2");
        bus0.soft_rst = 1'b0;
        tick(30);
        push(0, cyc, 4'b0000, 3'd0, 1'b0, 1'b0, "soft at idx2");
        bus0.soft_rst = 1'b1;
        tick(10);
        u = cyc;
        push(0, u + 3,  4'b0001, 3'd0, 1'b0, 1'b0, "soft2 rel0");
        push(0, u + 14, 4'b0011, 3'd1, 1'b0, 1'b0, "soft2 rel1");
        push(0, u + 25, 4'b0111, 3'd2, 1'b0, 1'b0, "soft2 rel2");
        push(0, u + 36, 4'b1111, 3'd3, 1'b0, 1'b0, "soft2 rel3");
        push(0, u + 47, 4'b1111, 3'd3, 1'b1, 1'b0, "soft2 done");
        bus0.soft_rst = 1'b0;
        tick(60);
    endtask

    task automatic seq1();
        int c;
        tick(3);
        c = cyc;
        push(1, c + 3,  4'b0001, 3'd0, 1'b0, 1'b0, "to rel0");
        push(1, c + 14, 4'b0011, 3'd1, 1'b0, 1'b0, "to rel1");
        push(1, c + 44, 4'b0011, 3'd1, 1'b0, 1'b1, "to fault");
        bus1.rstn = 1'b1;
        tick(70);
        push(1, cyc, 4'b0000, 3'd0, 1'b0, 1'b0, "fault cleared");
        bus1.rstn = 1'b0;
        tick(3);
        bus1.stage_ack = 4'b1110;
        c = cyc;
        push(1, c + 3,  4'b0001, 3'd0, 1'b0, 1'b0, "prio rel0");
        push(1, c + 33, 4'b0011, 3'd1, 1'b0, 1'b0, "prio ack wins");
        push(1, c + 44, 4'b0111, 3'd2, 1'b0, 1'b0, "prio rel2");
        push(1, c + 55, 4'b1111, 3'd3, 1'b0, 1'b0, "prio rel3");
        push(1, c + 66, 4'b1111, 3'd3, 1'b1, 1'b0, "prio done");
        bus1.rstn = 1'b1;
        tick(32);
        bus1.stage_ack = 4'b1111;
        tick(50);
    endtask

    initial begin
        bus0.rstn      = 1'b1;
        bus0.rst_done  = 1'b1;
        bus0.soft_rst  = 1'b0;
        bus0.stage_ack = 4'b1111;
        bus1.rstn      = 1'b1;
        bus1.rst_done  = 1'b1;
        bus1.soft_rst  = 1'b0;
        bus1.stage_ack = 4'b1101;
        push(0, -1, 4'b0000, 3'd0, 1'b0, 1'b0, "reset state");
        push(1, -1, 4'b0000, 3'd0, 1'b0, 1'b0, "reset state");
        #1;
        bus0.rstn = 1'b0;
        bus1.rstn = 1'b0;
        fork
            seq0();
            seq1();
        join
        tick(5);
        chk("dut0 events left", exp0.size(), 0);
        chk("dut1 events left", exp1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
